// File: rtl/qram_responder.sv
// qram_responder: memory-side responder for the QRAM command interface.
// Accepts writes and reads over a valid/ready command channel, stores words in an internal
// array, returns read data over a valid/ready response channel after a fixed latency, and runs
// its own power-up wait and periodic refresh, stalling commands while either is in progress.
//
// Ports:
//   Clock          in   sole clock, rising edge
//   nReset         in   asynchronous active-low reset
//   CmdValid       in   command present
//   CmdReady       out  responder can accept a command (IDLE and no refresh pending)
//   CmdWrite       in   1 = write, 0 = read
//   CmdAddr        in   target address
//   CmdData        in   write data
//   RspValid       out  read data present
//   RspReady       in   initiator accepts the read data
//   RspData        out  read data, held until the next read returns
//   InitDone       out  power-up wait complete
//   RefreshBusy    out  refresh in progress
//   RefreshOverrun out  sticky: a refresh request was lost
module qram_responder #(
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned READ_LAT       = 2,
  parameter int unsigned INIT_CYCLES    = 4,
  parameter int unsigned REFRESH_PERIOD = 32,
  parameter int unsigned REFRESH_CYCLES = 3
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              CmdValid,
  output logic              CmdReady,
  input  logic              CmdWrite,
  input  logic [ADDR_W-1:0] CmdAddr,
  input  logic [DATA_W-1:0] CmdData,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [DATA_W-1:0] RspData,
  output logic              InitDone,
  output logic              RefreshBusy,
  output logic              RefreshOverrun
);

  localparam int unsigned Words   = 1 << ADDR_W;
  localparam int unsigned InitW   = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int unsigned LatW    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam int unsigned RefCycW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int unsigned TmrW    = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;

  localparam logic [InitW-1:0]   InitLast = InitW'(INIT_CYCLES - 1);
  localparam logic [LatW-1:0]    LatLast  = LatW'(READ_LAT - 1);
  localparam logic [RefCycW-1:0] RefLast  = RefCycW'(REFRESH_CYCLES - 1);
  localparam logic [TmrW-1:0]    TmrLast  = TmrW'(REFRESH_PERIOD - 1);

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StRdWait,
    StRsp,
    StRefresh
  } state_e;

  state_e              state_q;
  logic [InitW-1:0]    init_cnt_q;
  logic [LatW-1:0]     lat_cnt_q;
  logic [RefCycW-1:0]  ref_cnt_q;
  logic [TmrW-1:0]     tmr_q;
  logic                pending_q;
  logic                overrun_q;
  logic                init_done_q;
  logic                rsp_valid_q;
  logic                busy_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic [DATA_W-1:0]   mem_q [Words];

  logic tmr_wrap;
  logic refresh_entry;
  logic cmd_ready;

  always_comb begin
    tmr_wrap      = (state_q != StInit) && (tmr_q == TmrLast);
    refresh_entry = (state_q == StIdle) && pending_q;
    // Depends only on state and pending, never on CmdValid.
    cmd_ready     = (state_q == StIdle) && !pending_q;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q     <= StInit;
      init_cnt_q  <= '0;
      lat_cnt_q   <= '0;
      ref_cnt_q   <= '0;
      tmr_q       <= '0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      addr_q      <= '0;
      rsp_data_q  <= '0;
      for (int i = 0; i < int'(Words); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      // Refresh timer: parked at 0 during the power-up wait, free-running afterwards.
      if (state_q == StInit || tmr_wrap) begin
        tmr_q <= '0;
      end else begin
        tmr_q <= tmr_q + 1'b1;
      end

      // A wrap on the same edge as refresh entry re-arms pending; only a wrap onto a
      // request that is still waiting counts as lost.
      if (tmr_wrap) begin
        pending_q <= 1'b1;
        if (pending_q && !refresh_entry) begin
          overrun_q <= 1'b1;
        end
      end else if (refresh_entry) begin
        pending_q <= 1'b0;
      end

      unique case (state_q)
        StInit: begin
          if (init_cnt_q == InitLast) begin
            state_q     <= StIdle;
            init_done_q <= 1'b1;
          end else begin
            init_cnt_q <= init_cnt_q + 1'b1;
          end
        end
        StIdle: begin
          if (pending_q) begin
            state_q   <= StRefresh;
            busy_q    <= 1'b1;
            ref_cnt_q <= '0;
          end else if (CmdValid) begin
            if (CmdWrite) begin
              mem_q[CmdAddr] <= CmdData;
            end else begin
              addr_q    <= CmdAddr;
              lat_cnt_q <= '0;
              state_q   <= StRdWait;
            end
          end
        end
        StRdWait: begin
          if (lat_cnt_q == LatLast) begin
            state_q     <= StRsp;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= mem_q[addr_q];
          end else begin
            lat_cnt_q <= lat_cnt_q + 1'b1;
          end
        end
        StRsp: begin
          if (RspReady) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
          end
        end
        StRefresh: begin
          if (ref_cnt_q == RefLast) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            ref_cnt_q <= ref_cnt_q + 1'b1;
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

  assign CmdReady       = cmd_ready;
  assign RspValid       = rsp_valid_q;
  assign RspData        = rsp_data_q;
  assign InitDone       = init_done_q;
  assign RefreshBusy    = busy_q;
  assign RefreshOverrun = overrun_q;

endmodule

// File: tb/tb_qram_responder.sv
// Self-checking bench for qram_responder with default parameters.
module tb_qram_responder;

  logic       Clock;
  logic       nReset;
  logic       CmdValid;
  logic       CmdReady;
  logic       CmdWrite;
  logic [3:0] CmdAddr;
  logic [7:0] CmdData;
  logic       RspValid;
  logic       RspReady;
  logic [7:0] RspData;
  logic       InitDone;
  logic       RefreshBusy;
  logic       RefreshOverrun;

  int n_chk  = 0;
  int n_fail = 0;

  qram_responder dut (
    .Clock         (Clock),
    .nReset        (nReset),
    .CmdValid      (CmdValid),
    .CmdReady      (CmdReady),
    .CmdWrite      (CmdWrite),
    .CmdAddr       (CmdAddr),
    .CmdData       (CmdData),
    .RspValid      (RspValid),
    .RspReady      (RspReady),
    .RspData       (RspData),
    .InitDone      (InitDone),
    .RefreshBusy   (RefreshBusy),
    .RefreshOverrun(RefreshOverrun)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] data;  // write data, or expected read data
    int         hold;  // cycles RspReady is held low during the response
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_ready(input string name);
    for (int k = 0; k < 64 && !CmdReady; k++) step();
    chk(name, {31'b0, CmdReady}, 32'd1);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    CmdValid = 1'b1;
    CmdWrite = 1'b1;
    CmdAddr  = a;
    CmdData  = d;
    wait_ready("wr_ready");
    step();
    CmdValid = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [7:0] exp, input int hold);
    CmdValid = 1'b1;
    CmdWrite = 1'b0;
    CmdAddr  = a;
    wait_ready("rd_ready");
    step();  // accept edge E
    CmdValid = 1'b0;
    chk("rd_lat1_valid", {31'b0, RspValid}, 32'd0);
    chk("rd_busy_ready", {31'b0, CmdReady}, 32'd0);
    step();  // E+1
    chk("rd_lat2_valid", {31'b0, RspValid}, 32'd0);
    step();  // E+2
    chk("rd_valid", {31'b0, RspValid}, 32'd1);
    chk("rd_data", {24'b0, RspData}, {24'b0, exp});
    RspReady = 1'b0;
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_valid", {31'b0, RspValid}, 32'd1);
      chk("hold_data", {24'b0, RspData}, {24'b0, exp});
      chk("hold_ready", {31'b0, CmdReady}, 32'd0);
    end
    RspReady = 1'b1;
    step();  // handshake edge
    chk("rsp_done_valid", {31'b0, RspValid}, 32'd0);
  endtask

  // Assert reset, release, and run the power-up wait; returns just after the 4th edge.
  task automatic reset_dut();
    nReset = 1'b0;
    step();
    step();
    nReset = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      step();
      chk("init_done", {31'b0, InitDone}, (e == 4) ? 32'd1 : 32'd0);
      chk("init_ready", {31'b0, CmdReady}, (e == 4) ? 32'd1 : 32'd0);
    end
  endtask

  vec_t vecs[5];

  initial begin
    logic exp_busy;
    logic exp_rdy;

    vecs[0] = '{wr: 1'b1, addr: 4'd3, data: 8'hA5, hold: 0};
    vecs[1] = '{wr: 1'b0, addr: 4'd3, data: 8'hA5, hold: 0};
    vecs[2] = '{wr: 1'b0, addr: 4'd9, data: 8'h00, hold: 0};
    vecs[3] = '{wr: 1'b1, addr: 4'd3, data: 8'h6E, hold: 0};
    vecs[4] = '{wr: 1'b0, addr: 4'd3, data: 8'h6E, hold: 5};

    nReset   = 1'b1;
    CmdValid = 1'b0;
    CmdWrite = 1'b0;
    CmdAddr  = '0;
    CmdData  = '0;
    RspReady = 1'b1;
    #2 nReset = 1'b0;
    #1;
    chk("rst_ready", {31'b0, CmdReady}, 32'd0);
    chk("rst_valid", {31'b0, RspValid}, 32'd0);
    chk("rst_data", {24'b0, RspData}, 32'd0);
    chk("rst_initdone", {31'b0, InitDone}, 32'd0);
    chk("rst_busy", {31'b0, RefreshBusy}, 32'd0);
    chk("rst_overrun", {31'b0, RefreshOverrun}, 32'd0);

    reset_dut();  // now just after edge I (InitDone rose)

    // Idle refresh cadence: pending on I+32/I+64, busy on I+33..35 and I+65..67.
    for (int i = 1; i <= 70; i++) begin
      step();
      exp_busy = (i >= 33 && i <= 35) || (i >= 65 && i <= 67);
      exp_rdy  = !((i >= 32 && i <= 35) || (i >= 64 && i <= 67));
      chk("idle_busy", {31'b0, RefreshBusy}, {31'b0, exp_busy});
      chk("idle_ready", {31'b0, CmdReady}, {31'b0, exp_rdy});
    end
    for (int i = 71; i <= 97; i++) step();
    chk("ref3_busy", {31'b0, RefreshBusy}, 32'd1);
    // Command held through the refresh must go in on the first IDLE cycle.
    CmdValid = 1'b1;
    CmdWrite = 1'b1;
    CmdAddr  = 4'd7;
    CmdData  = 8'h77;
    step();
    chk("ref3_ready_a", {31'b0, CmdReady}, 32'd0);
    step();
    chk("ref3_ready_b", {31'b0, CmdReady}, 32'd0);
    step();
    chk("ref3_end_busy", {31'b0, RefreshBusy}, 32'd0);
    chk("ref3_end_ready", {31'b0, CmdReady}, 32'd1);
    step();
    CmdValid = 1'b0;
    do_read(4'd7, 8'h77, 0);

    // Table-driven basic write/read, including a 5-cycle response stall.
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].wr) do_write(vecs[v].addr, vecs[v].data);
      else do_read(vecs[v].addr, vecs[v].data, vecs[v].hold);
    end

    // Fill the whole array, then read it back.
    for (int a = 0; a < 16; a++) do_write(4'(a), 8'(8'h10 + a));
    for (int a = 0; a < 16; a++) do_read(4'(a), 8'(8'h10 + a), 0);

    // Long stall: two refresh wraps pile up and one is lost.
    reset_dut();
    do_write(4'd2, 8'h5A);
    chk("ovr_before", {31'b0, RefreshOverrun}, 32'd0);
    do_read(4'd2, 8'h5A, 70);
    chk("ovr_set", {31'b0, RefreshOverrun}, 32'd1);
    chk("ovr_pend_ready", {31'b0, CmdReady}, 32'd0);
    chk("ovr_busy0", {31'b0, RefreshBusy}, 32'd0);
    chk("ovr_data", {24'b0, RspData}, 32'h5A);
    step();
    chk("ovr_busy1", {31'b0, RefreshBusy}, 32'd1);
    step();
    step();
    chk("ovr_busy3", {31'b0, RefreshBusy}, 32'd1);
    step();
    chk("ovr_busy_end", {31'b0, RefreshBusy}, 32'd0);
    chk("ovr_single_ready", {31'b0, CmdReady}, 32'd1);
    chk("ovr_sticky", {31'b0, RefreshOverrun}, 32'd1);

    // Reset while a read sits in RD_WAIT.
    do_write(4'd5, 8'h3C);
    CmdValid = 1'b1;
    CmdWrite = 1'b0;
    CmdAddr  = 4'd5;
    wait_ready("mid_ready");
    step();
    CmdValid = 1'b0;
    step();
    nReset = 1'b0;
    #1;
    chk("mid_ready0", {31'b0, CmdReady}, 32'd0);
    chk("mid_valid0", {31'b0, RspValid}, 32'd0);
    chk("mid_data0", {24'b0, RspData}, 32'd0);
    chk("mid_initdone0", {31'b0, InitDone}, 32'd0);
    chk("mid_busy0", {31'b0, RefreshBusy}, 32'd0);
    chk("mid_overrun0", {31'b0, RefreshOverrun}, 32'd0);
    step();
    chk("mid_hold_valid", {31'b0, RspValid}, 32'd0);
    nReset = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      step();
      chk("mid_init_done", {31'b0, InitDone}, (e == 4) ? 32'd1 : 32'd0);
    end
    do_read(4'd5, 8'h00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
